// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: SPI register map,
// STATUS bit positions, step/phase enums and the captured request payload.
package spi_seq_pkg;

  localparam int unsigned APB_DW = 32;

  localparam logic [7:0] REG_STATUS = 8'h00;
  localparam logic [7:0] REG_CLKDIV = 8'h04;
  localparam logic [7:0] REG_SPICMD = 8'h08;
  localparam logic [7:0] REG_SPIADR = 8'h0C;
  localparam logic [7:0] REG_SPILEN = 8'h10;
  localparam logic [7:0] REG_SPIDUM = 8'h14;
  localparam logic [7:0] REG_TXFIFO = 8'h18;
  localparam logic [7:0] REG_RXFIFO = 8'h20;

  localparam int unsigned ST_RD     = 0;
  localparam int unsigned ST_WR     = 1;
  localparam int unsigned ST_SWRST  = 4;
  localparam int unsigned ST_CS_LSB = 8;
  localparam int unsigned ST_IDLE   = 0;

  typedef enum logic [3:0] {
    STEP_IDLE, STEP_CLKDIV, STEP_CMD, STEP_ADR, STEP_LEN, STEP_DUM, STEP_TX,
    STEP_START, STEP_POLL, STEP_GAP, STEP_RX, STEP_SWRST, STEP_RESP
  } step_e;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} apb_phase_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  csn;
    logic [7:0]  clkdiv;
    logic [31:0] cmd;
    logic [5:0]  cmd_len;
    logic [31:0] addr;
    logic [5:0]  addr_len;
    logic [5:0]  data_len;
    logic [15:0] dummy_rd;
    logic [15:0] dummy_wr;
    logic [31:0] wdata;
  } req_t;

  // STATUS word that launches a standard-mode transfer on the selected chip select
  function automatic logic [31:0] status_start(input logic write, input logic [1:0] csn);
    logic [31:0] w;
    w = '0;
    w[ST_CS_LSB +: 4] = 4'b0001 << csn;
    w[ST_WR] = write;
    w[ST_RD] = ~write;
    return w;
  endfunction

  localparam logic [31:0] SWRST_WORD = 32'(1) << ST_SWRST;

endpackage

// File: rtl/spi_seq_apb_xact.sv
// Single-access APB master engine: SETUP then ACCESS until PREADY.
// Completion, read data and error are presented combinationally on the finishing cycle.
module spi_seq_apb_xact
  import spi_seq_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [AW-1:0]     addr,
  input  logic [APB_DW-1:0] wdata,
  input  logic              write,
  output logic              done_c,
  output logic [APB_DW-1:0] rdata_c,
  output logic              err_c,
  output logic [AW-1:0]     PADDR,
  output logic [APB_DW-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_phase_e        phase, phase_n;
  logic              psel_n, penable_n, pwrite_n;
  logic [AW-1:0]     paddr_n;
  logic [APB_DW-1:0] pwdata_n;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      phase   <= PH_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      phase   <= phase_n;
      PSEL    <= psel_n;
      PENABLE <= penable_n;
      PWRITE  <= pwrite_n;
      PADDR   <= paddr_n;
      PWDATA  <= pwdata_n;
    end
  end

  // Address/data/direction are latched at start and held through both phases
  always_comb begin
    phase_n   = phase;
    psel_n    = PSEL;
    penable_n = PENABLE;
    pwrite_n  = PWRITE;
    paddr_n   = PADDR;
    pwdata_n  = PWDATA;
    unique case (phase)
      PH_IDLE: begin
        if (start) begin
          phase_n   = PH_SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          pwrite_n  = write;
          paddr_n   = addr;
          pwdata_n  = wdata;
        end
      end
      PH_SETUP: begin
        phase_n   = PH_ACCESS;
        penable_n = 1'b1;
      end
      PH_ACCESS: begin
        if (PREADY) begin
          phase_n   = PH_IDLE;
          psel_n    = 1'b0;
          penable_n = 1'b0;
        end
      end
      default: phase_n = PH_IDLE;
    endcase
  end

  assign done_c  = (phase == PH_ACCESS) && PREADY;
  assign rdata_c = PRDATA;
  assign err_c   = done_c && PSLVERR;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Autonomous APB master that programs the SPI register set for one request,
// launches it, polls STATUS until idle, optionally fetches one RX word and responds.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned POLL_TIMEOUT   = 1024,
  parameter int unsigned POLL_GAP       = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_csn,
  input  logic [7:0]                req_clkdiv,
  input  logic [31:0]               req_cmd,
  input  logic [5:0]                req_cmd_len,
  input  logic [31:0]               req_addr,
  input  logic [5:0]                req_addr_len,
  input  logic [5:0]                req_data_len,
  input  logic [15:0]               req_dummy_rd,
  input  logic [15:0]               req_dummy_wr,
  input  logic [31:0]               req_wdata,
  output logic                      rsp_valid,
  output logic                      rsp_err,
  output logic [31:0]               rsp_rdata,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 2);

  step_e          state, state_n;
  req_t           req_r, req_n;
  logic           pend, pend_n;
  logic [PW-1:0]  poll_cnt, poll_cnt_n;
  logic [GW-1:0]  gap_cnt, gap_cnt_n;
  logic           err_r, err_n;
  logic [31:0]    rdata_r, rdata_n;
  logic           is_acc, start, xwrite;
  logic [7:0]     xaddr;
  logic [31:0]    xwdata;
  logic           done_c, err_c;
  logic [31:0]    rdata_c;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= STEP_IDLE;
      req_r     <= '0;
      pend      <= 1'b0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      err_r     <= 1'b0;
      rdata_r   <= '0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      req_r     <= req_n;
      pend      <= pend_n;
      poll_cnt  <= poll_cnt_n;
      gap_cnt   <= gap_cnt_n;
      err_r     <= err_n;
      rdata_r   <= rdata_n;
      rsp_valid <= (state_n == STEP_RESP);
      req_ready <= (state_n == STEP_IDLE);
      busy      <= (state_n != STEP_IDLE);
    end
  end

  // Register access carried out by each bus step
  always_comb begin
    is_acc = 1'b1;
    xaddr  = REG_STATUS;
    xwdata = '0;
    xwrite = 1'b1;
    unique case (state)
      STEP_CLKDIV: begin xaddr = REG_CLKDIV; xwdata = {24'd0, req_r.clkdiv}; end
      STEP_CMD:    begin xaddr = REG_SPICMD; xwdata = req_r.cmd; end
      STEP_ADR:    begin xaddr = REG_SPIADR; xwdata = req_r.addr; end
      STEP_LEN:    begin
        xaddr  = REG_SPILEN;
        xwdata = {10'd0, req_r.data_len, 2'd0, req_r.addr_len, 2'd0, req_r.cmd_len};
      end
      STEP_DUM:    begin xaddr = REG_SPIDUM; xwdata = {req_r.dummy_wr, req_r.dummy_rd}; end
      STEP_TX:     begin xaddr = REG_TXFIFO; xwdata = req_r.wdata; end
      STEP_START:  xwdata = status_start(req_r.write, req_r.csn);
      STEP_POLL:   xwrite = 1'b0;
      STEP_RX:     begin xaddr = REG_RXFIFO; xwrite = 1'b0; end
      STEP_SWRST:  xwdata = SWRST_WORD;
      default:     is_acc = 1'b0;
    endcase
  end

  assign start = is_acc && !pend;

  always_comb begin
    state_n    = state;
    req_n      = req_r;
    pend_n     = pend;
    poll_cnt_n = poll_cnt;
    gap_cnt_n  = gap_cnt;
    err_n      = err_r;
    rdata_n    = rdata_r;
    if (start) pend_n = 1'b1;
    unique case (state)
      STEP_IDLE: begin
        if (req_valid && req_ready) begin
          req_n.write    = req_write;
          req_n.csn      = req_csn;
          req_n.clkdiv   = req_clkdiv;
          req_n.cmd      = req_cmd;
          req_n.cmd_len  = req_cmd_len;
          req_n.addr     = req_addr;
          req_n.addr_len = req_addr_len;
          req_n.data_len = req_data_len;
          req_n.dummy_rd = req_dummy_rd;
          req_n.dummy_wr = req_dummy_wr;
          req_n.wdata    = req_wdata;
          err_n          = 1'b0;
          rdata_n        = '0;
          poll_cnt_n     = '0;
          if ((req_data_len == 6'd0) || (req_data_len > 6'd32)) begin
            err_n   = 1'b1;
            state_n = STEP_RESP;
          end else begin
            state_n = STEP_CLKDIV;
          end
        end
      end
      STEP_GAP: begin
        if (gap_cnt <= GW'(1)) state_n = STEP_POLL;
        else gap_cnt_n = gap_cnt - GW'(1);
      end
      STEP_RESP: state_n = STEP_IDLE;
      default: begin
        if (done_c) begin
          pend_n = 1'b0;
          if (err_c) begin
            // A bus error while the SPI core is running still needs a soft reset
            err_n   = 1'b1;
            state_n = (state == STEP_POLL) ? STEP_SWRST : STEP_RESP;
          end else begin
            unique case (state)
              STEP_CLKDIV: state_n = STEP_CMD;
              STEP_CMD:    state_n = STEP_ADR;
              STEP_ADR:    state_n = STEP_LEN;
              STEP_LEN:    state_n = STEP_DUM;
              STEP_DUM:    state_n = req_r.write ? STEP_TX : STEP_START;
              STEP_TX:     state_n = STEP_START;
              STEP_START:  state_n = STEP_POLL;
              STEP_POLL: begin
                poll_cnt_n = poll_cnt + PW'(1);
                if (rdata_c[ST_IDLE]) begin
                  state_n = req_r.write ? STEP_RESP : STEP_RX;
                end else if (poll_cnt + PW'(1) == PW'(POLL_TIMEOUT)) begin
                  err_n   = 1'b1;
                  state_n = STEP_SWRST;
                end else if (POLL_GAP == 0) begin
                  state_n = STEP_POLL;
                end else begin
                  gap_cnt_n = GW'(POLL_GAP);
                  state_n   = STEP_GAP;
                end
              end
              STEP_RX: begin
                rdata_n = rdata_c;
                state_n = STEP_RESP;
              end
              default: state_n = STEP_RESP;
            endcase
          end
        end
      end
    endcase
  end

  spi_seq_apb_xact #(.AW(APB_ADDR_WIDTH)) u_xact (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .start   (start),
    .addr    (APB_ADDR_WIDTH'(xaddr)),
    .wdata   (xwdata),
    .write   (xwrite),
    .done_c  (done_c),
    .rdata_c (rdata_c),
    .err_c   (err_c),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  assign rsp_err   = err_r;
  assign rsp_rdata = rdata_r;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Scoreboard bench for spi_xfer_sequencer: a reference model predicts every APB
// access and the response; an APB slave model and monitors compare against it.
module tb_spi_xfer_sequencer;

  localparam int unsigned AW  = 12;
  localparam int unsigned TO  = 4;
  localparam int unsigned GAP = 2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_csn = '0;
  logic [7:0] req_clkdiv = '0;
  logic [31:0] req_cmd = '0, req_addr = '0, req_wdata = '0;
  logic [5:0] req_cmd_len = '0, req_addr_len = '0, req_data_len = '0;
  logic [15:0] req_dummy_rd = '0, req_dummy_wr = '0;
  logic req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0] PWDATA;
  logic PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA = '0;
  logic PREADY = 1'b0, PSLVERR = 1'b0;

  always #5 HCLK = ~HCLK;

  spi_xfer_sequencer #(.APB_ADDR_WIDTH(AW), .POLL_TIMEOUT(TO), .POLL_GAP(GAP)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_csn(req_csn),
    .req_clkdiv(req_clkdiv), .req_cmd(req_cmd), .req_cmd_len(req_cmd_len), .req_addr(req_addr),
    .req_addr_len(req_addr_len), .req_data_len(req_data_len), .req_dummy_rd(req_dummy_rd),
    .req_dummy_wr(req_dummy_wr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        write;
    logic [1:0]  csn;
    logic [7:0]  clkdiv;
    logic [31:0] cmd;
    logic [5:0]  cmd_len;
    logic [31:0] addr;
    logic [5:0]  addr_len;
    logic [5:0]  data_len;
    logic [15:0] drd;
    logic [15:0] dwr;
    logic [31:0] wdata;
  } treq_t;

  typedef struct { logic [AW-1:0] addr; logic write; logic [31:0] wdata; int en; } acc_t;
  typedef struct { logic err; logic [31:0] rdata; } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int n_pass = 0;
  int n_total = 0;

  // Slave scenario for the transaction in flight (index = APB access number)
  int sc_idle_at = 1;
  int sc_err_idx = -1;
  int sc_ws_idx = -1;
  int sc_ws = 0;
  logic [31:0] sc_rx = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, required %08h", nm, act, exp);
  endtask

  task automatic fail(input string nm, input string why);
    n_total++;
    $display("FAIL %s: %s", nm, why);
  endtask

  function automatic acc_t mk(input logic [AW-1:0] a, input logic w, input logic [31:0] d);
    acc_t x;
    x.addr = a; x.write = w; x.wdata = d; x.en = 1;
    return x;
  endfunction

  // Reference model: list of register accesses and the final response
  task automatic model(input treq_t r);
    acc_t l[$];
    rsp_t rs;
    int first_poll, npoll;
    logic tmo, err;
    if (r.data_len == 0 || r.data_len > 32) begin
      rs.err = 1'b1; rs.rdata = '0;
      exp_rsp.push_back(rs);
      return;
    end
    l.push_back(mk(12'h004, 1'b1, {24'd0, r.clkdiv}));
    l.push_back(mk(12'h008, 1'b1, r.cmd));
    l.push_back(mk(12'h00C, 1'b1, r.addr));
    l.push_back(mk(12'h010, 1'b1, (32'(r.data_len) << 16) | (32'(r.addr_len) << 8) | 32'(r.cmd_len)));
    l.push_back(mk(12'h014, 1'b1, {r.dwr, r.drd}));
    if (r.write) l.push_back(mk(12'h018, 1'b1, r.wdata));
    l.push_back(mk(12'h000, 1'b1, (32'd1 << (8 + int'(r.csn))) | (r.write ? 32'd2 : 32'd1)));
    first_poll = l.size();
    tmo = !(sc_idle_at >= 1 && sc_idle_at <= int'(TO));
    npoll = tmo ? int'(TO) : sc_idle_at;
    for (int i = 0; i < npoll; i++) l.push_back(mk(12'h000, 1'b0, 32'd0));
    if (tmo) l.push_back(mk(12'h000, 1'b1, 32'h10));
    else if (!r.write) l.push_back(mk(12'h020, 1'b0, 32'd0));
    err = tmo;
    if (sc_err_idx >= 0 && sc_err_idx < l.size()) begin
      err = 1'b1;
      while (l.size() > sc_err_idx + 1) void'(l.pop_back());
      if (sc_err_idx >= first_poll && sc_err_idx < first_poll + npoll)
        l.push_back(mk(12'h000, 1'b1, 32'h10));
    end
    for (int i = 0; i < l.size(); i++) begin
      if (i == sc_ws_idx) l[i].en = sc_ws + 1;
      exp_acc.push_back(l[i]);
    end
    rs.err = err;
    rs.rdata = (!err && !r.write) ? sc_rx : 32'd0;
    exp_rsp.push_back(rs);
  endtask

  // APB slave: responds according to the scenario, one step after each clock edge
  int acc_idx = 0, polls = 0, wcnt = 0;
  logic completing = 1'b0;
  always @(posedge HCLK) begin
    #1;
    if (completing) begin acc_idx++; completing = 1'b0; end
    if (!busy) begin acc_idx = 0; polls = 0; end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    if (HRESETn && PSEL && PENABLE) begin
      if (acc_idx == sc_ws_idx && wcnt < sc_ws) begin
        wcnt++;
      end else begin
        PREADY = 1'b1;
        wcnt = 0;
        completing = 1'b1;
        PSLVERR = (acc_idx == sc_err_idx);
        if (!PWRITE && PADDR == 12'h000) begin
          polls++;
          PRDATA = $urandom;
          PRDATA[0] = (polls == sc_idle_at);
        end else if (!PWRITE && PADDR == 12'h020) begin
          PRDATA = sc_rx;
        end else begin
          PRDATA = $urandom;
        end
      end
    end else begin
      wcnt = 0;
    end
  end

  // Monitor: compares completed APB accesses and responses against the queues
  logic [AW-1:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic s_write = 1'b0, prev_psel = 1'b0, prev_rsp = 1'b0;
  int en_cnt = 0;
  always @(negedge HCLK) begin
    acc_t e;
    rsp_t r;
    if (!HRESETn) begin
      prev_psel = 1'b0;
      prev_rsp = 1'b0;
    end else begin
      if (PSEL && !PENABLE) begin
        chk("psel_gap", 32'(prev_psel), 32'd0);
        s_addr = PADDR; s_wdata = PWDATA; s_write = PWRITE; en_cnt = 0;
      end
      if (PSEL && PENABLE) begin
        en_cnt++;
        if (PREADY) begin
          if (exp_acc.size() == 0) begin
            fail("unexpected_access", $sformatf("addr %03h write %0d, required no access", PADDR, PWRITE));
          end else begin
            e = exp_acc.pop_front();
            chk("acc_addr", 32'(PADDR), 32'(e.addr));
            chk("acc_write", 32'(PWRITE), 32'(e.write));
            if (e.write) chk("acc_wdata", PWDATA, e.wdata);
            chk("acc_enable_cycles", 32'(en_cnt), 32'(e.en));
            chk("acc_stable", {PWDATA[19:0], PADDR}, {s_wdata[19:0], s_addr});
            chk("acc_stable_dir", 32'(PWRITE), 32'(s_write));
          end
        end
      end
      if (prev_rsp) begin
        chk("rsp_pulse_len", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          fail("unexpected_rsp", "response with nothing outstanding");
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(r.err));
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_pending_acc", exp_acc.size(), 32'd0);
        end
      end
      prev_psel = PSEL;
      prev_rsp = rsp_valid;
    end
  end

  task automatic issue(input treq_t r);
    model(r);
    @(negedge HCLK);
    req_write = r.write; req_csn = r.csn; req_clkdiv = r.clkdiv; req_cmd = r.cmd;
    req_cmd_len = r.cmd_len; req_addr = r.addr; req_addr_len = r.addr_len;
    req_data_len = r.data_len; req_dummy_rd = r.drd; req_dummy_wr = r.dwr; req_wdata = r.wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge HCLK);
    if (!req_ready) fail("req_accept", "req_ready never rose, required 1");
    @(posedge HCLK);
    #1;
    req_valid = 1'b0;
    req_cmd = $urandom; req_addr = $urandom; req_wdata = $urandom;
    req_data_len = 6'($urandom); req_write = ~req_write; req_csn = 2'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && exp_rsp.size() != 0; i++) @(negedge HCLK);
    if (exp_rsp.size() != 0) fail("rsp_timeout", "no response, required one");
    @(negedge HCLK);
  endtask

  function automatic treq_t base(input logic w);
    treq_t r;
    r.write = w; r.csn = 2'd0; r.clkdiv = 8'h03; r.cmd = 32'h0B00_0000; r.cmd_len = 6'd8;
    r.addr = 32'h0001_0000; r.addr_len = 6'd32; r.data_len = 6'd32;
    r.drd = 16'd8; r.dwr = 16'd0; r.wdata = 32'hAAAA_AAAA;
    return r;
  endfunction

  function automatic treq_t rand_req();
    treq_t r;
    r.write = 1'($urandom); r.csn = 2'($urandom); r.clkdiv = 8'($urandom);
    r.cmd = $urandom; r.cmd_len = 6'($urandom); r.addr = $urandom; r.addr_len = 6'($urandom);
    r.drd = 16'($urandom); r.dwr = 16'($urandom); r.wdata = $urandom;
    if ($urandom_range(0, 9) == 0) r.data_len = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
    else r.data_len = 6'($urandom_range(1, 32));
    return r;
  endfunction

  task automatic scen(input int idle_at, input int err_idx, input int ws_idx, input int ws, input logic [31:0] rx);
    sc_idle_at = idle_at; sc_err_idx = err_idx; sc_ws_idx = ws_idx; sc_ws = ws; sc_rx = rx;
  endtask

  initial begin
    treq_t r;
    repeat (3) @(negedge HCLK);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_psel_penable", {PSEL, PENABLE}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    HRESETn = 1'b1;

    scen(1, -1, -1, 0, 32'd0);
    issue(base(1'b1)); wait_done();

    scen(3, -1, -1, 0, 32'h1234_5678);
    r = base(1'b0); r.csn = 2'd2;
    issue(r); wait_done();

    scen(2, -1, 3, 5, 32'd0);
    issue(base(1'b1)); wait_done();

    scen(1, 2, -1, 0, 32'hDEAD_BEEF);
    issue(base(1'b0)); wait_done();

    scen(0, -1, -1, 0, 32'hCAFE_F00D);
    issue(base(1'b0)); wait_done();

    scen(1, -1, -1, 0, 32'd0);
    r = base(1'b1); r.data_len = 6'd0; issue(r); wait_done();
    r.data_len = 6'd40; issue(r); wait_done();
    r.data_len = 6'd1; r.write = 1'b0; sc_rx = 32'h0000_0055; issue(r); wait_done();

    // Reset in the middle of a stretched ACCESS phase
    scen(1, -1, 2, 50, 32'd0);
    issue(base(1'b0));
    for (int i = 0; i < 100 && !(PSEL && PENABLE && PADDR == 12'h00C); i++) @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst_drops_psel", {PSEL, PENABLE}, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    exp_acc.delete();
    exp_rsp.delete();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    scen(2, -1, -1, 0, 32'h0BAD_F00D);
    issue(base(1'b0)); wait_done();
    issue(base(1'b1)); wait_done();

    for (int t = 0; t < 30; t++) begin
      scen($urandom_range(0, 5),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
           int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), $urandom);
      issue(rand_req());
      wait_done();
    end

    chk("final_acc_queue", exp_acc.size(), 32'd0);
    chk("final_rsp_queue", exp_rsp.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
